// File: rtl/config_pkg.sv
// Core-wide configuration shared by the front-end predictors.
package config_pkg;
    localparam int unsigned VLEN = 64;
endpackage

// File: rtl/bht_unit.sv
// Branch history table: NR_ENTRIES 2-bit saturating counters indexed by PC,
// swept to weakly-not-taken after reset or flush, updated by a 2-stage RMW pipe.
module bht_unit
    import config_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] vpc_i,
    input  logic            upd_valid_i,
    input  logic            upd_is_branch_i,
    input  logic [VLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    output logic            init_done_o
);
    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

    typedef enum logic {INIT, RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
    logic [1:0]       table_q [NR_ENTRIES];

    logic             upd_valid_q;
    logic [IDX_W-1:0] upd_idx_q;
    logic             upd_taken_q;
    logic             pred_valid_q;
    logic             pred_taken_q;

    logic             run;
    logic             lookup_acc;
    logic             upd_acc;
    logic             upd_wr;
    logic             init_wr;
    logic [IDX_W-1:0] lookup_idx;
    logic [1:0]       upd_cnt;
    logic [1:0]       upd_next;

    assign run        = (state_q == RUN);
    assign lookup_idx = vpc_i[IDX_W+1:2];
    assign lookup_acc = lookup_valid_i && run && !flush_i;
    assign upd_acc    = upd_valid_i && upd_is_branch_i && run && !flush_i;
    // A pending stage-1 update dies if flush or reset lands in its write cycle.
    assign upd_wr     = upd_valid_q && run && !flush_i && !rst_i;
    assign init_wr    = !run && !flush_i && !rst_i;

    assign upd_cnt  = table_q[upd_idx_q];
    assign upd_next = upd_taken_q ? ((upd_cnt == 2'b11) ? 2'b11 : upd_cnt + 2'b01)
                                  : ((upd_cnt == 2'b00) ? 2'b00 : upd_cnt - 2'b01);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            INIT: begin
                if (flush_i) begin
                    init_idx_d = '0;
                end else if (init_idx_q == IDX_W'(NR_ENTRIES - 1)) begin
                    state_d    = RUN;
                    init_idx_d = '0;
                end else begin
                    init_idx_d = init_idx_q + IDX_W'(1);
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d    = INIT;
                    init_idx_d = '0;
                end
            end
            default: begin
                state_d    = INIT;
                init_idx_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which also gives read-before-write on the table.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= INIT;
            init_idx_q   <= '0;
            upd_valid_q  <= 1'b0;
            upd_idx_q    <= '0;
            upd_taken_q  <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            upd_valid_q  <= upd_acc;
            if (upd_acc) begin
                upd_idx_q   <= upd_pc_i[IDX_W+1:2];
                upd_taken_q <= upd_taken_i;
            end
            pred_valid_q <= lookup_acc;
            pred_taken_q <= lookup_acc && table_q[lookup_idx][1];
        end
    end

    // NOTE: the counter array has no reset; the INIT sweep is its only initialiser.
    always_ff @(posedge clk_i) begin
        if (init_wr) begin
            table_q[init_idx_q] <= 2'b01;
        end else if (upd_wr) begin
            table_q[upd_idx_q] <= upd_next;
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_taken_o = pred_taken_q;
    assign init_done_o  = run;

endmodule

// File: tb/tb_bht_unit.sv
// Self-checking bench for bht_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural table model.
module tb_bht_unit;
    import config_pkg::*;

    localparam int NR = 64;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            lookup_valid_i = 1'b0;
    logic [VLEN-1:0] vpc_i = '0;
    logic            upd_valid_i = 1'b0;
    logic            upd_is_branch_i = 1'b0;
    logic [VLEN-1:0] upd_pc_i = '0;
    logic            upd_taken_i = 1'b0;
    logic            pred_valid_o;
    logic            pred_taken_o;
    logic            init_done_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    bht_unit #(.NR_ENTRIES(NR)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .lookup_valid_i  (lookup_valid_i),
        .vpc_i           (vpc_i),
        .upd_valid_i     (upd_valid_i),
        .upd_is_branch_i (upd_is_branch_i),
        .upd_pc_i        (upd_pc_i),
        .upd_taken_i     (upd_taken_i),
        .pred_valid_o    (pred_valid_o),
        .pred_taken_o    (pred_taken_o),
        .init_done_o     (init_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt [NR];
    bit m_run;
    int m_init;
    bit m_pend;
    int m_pend_idx;
    bit m_pend_t;
    bit m_pv, m_pt;
    bit m_lk;

    function automatic int idx_of(input logic [VLEN-1:0] pc);
        return int'((pc >> 2) % VLEN'(NR));
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            m_run  = 0;
            m_init = 0;
            m_pend = 0;
            m_pv   = 0;
            m_pt   = 0;
        end else begin
            m_lk = lookup_valid_i && m_run && !flush_i;
            m_pv = m_lk;
            m_pt = m_lk && (m_cnt[idx_of(vpc_i)] >= 2);
            if (m_run && m_pend && !flush_i) begin
                if (m_pend_t) m_cnt[m_pend_idx] = (m_cnt[m_pend_idx] == 3) ? 3 : m_cnt[m_pend_idx] + 1;
                else          m_cnt[m_pend_idx] = (m_cnt[m_pend_idx] == 0) ? 0 : m_cnt[m_pend_idx] - 1;
            end
            m_pend     = upd_valid_i && upd_is_branch_i && m_run && !flush_i;
            m_pend_idx = idx_of(upd_pc_i);
            m_pend_t   = upd_taken_i;
            if (!m_run) begin
                if (flush_i) m_init = 0;
                else begin
                    m_cnt[m_init] = 1;
                    m_init++;
                    if (m_init == NR) begin
                        m_run  = 1;
                        m_init = 0;
                    end
                end
            end else if (flush_i) begin
                m_run  = 0;
                m_init = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_pred_valid", 32'(pred_valid_o), 32'(m_pv));
            check("cmp_pred_taken", 32'(pred_taken_o), 32'(m_pt));
            check("cmp_init_done",  32'(init_done_o),  32'(m_run));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic upd(input logic [VLEN-1:0] pc, input logic taken, input logic is_br);
        upd_valid_i     = 1'b1;
        upd_is_branch_i = is_br;
        upd_pc_i        = pc;
        upd_taken_i     = taken;
        tick();
        upd_valid_i     = 1'b0;
        upd_is_branch_i = 1'b0;
    endtask

    task automatic lookup_expect(input string name, input logic [VLEN-1:0] pc, input logic exp);
        lookup_valid_i = 1'b1;
        vpc_i          = pc;
        tick();
        lookup_valid_i = 1'b0;
        check({name, "_valid"}, 32'(pred_valid_o), 32'd1);
        check(name, 32'(pred_taken_o), 32'(exp));
    endtask

    task automatic flush_and_wait(input string name);
        int n;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check({name, "_done_low"}, 32'(init_done_o), 32'd0);
        n = 0;
        while (!init_done_o && n < 200) begin
            tick();
            n++;
        end
        check({name, "_init_cycles"}, 32'(n), 32'd64);
    endtask

    initial begin
        tick();
        tick();
        cmp_en = 1'b1;
        check("reset_pred_valid", 32'(pred_valid_o), 32'd0);
        check("reset_init_done",  32'(init_done_o),  32'd0);

        // Reset release with lookups held high through the whole sweep.
        lookup_valid_i = 1'b1;
        vpc_i          = VLEN'(32'h1000);
        rst_i          = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 64) lookup_valid_i = 1'b0;
            check($sformatf("init_done_c%0d", k), 32'(init_done_o), (k >= 64) ? 32'd1 : 32'd0);
            check($sformatf("init_lookup_c%0d", k), 32'(pred_valid_o), 32'd0);
        end

        // Back-to-back taken updates from 01 reach 11.
        upd(VLEN'(32'h1000), 1'b1, 1'b1);
        upd(VLEN'(32'h1000), 1'b1, 1'b1);
        tick();
        lookup_expect("b2b_taken", VLEN'(32'h1000), 1'b1);
        upd(VLEN'(32'h1000), 1'b0, 1'b1);
        tick();
        lookup_expect("b2b_was_11", VLEN'(32'h1000), 1'b1);

        // Saturate at 3, then two not-taken bring it to 01.
        for (int i = 0; i < 3; i++) upd(VLEN'(32'h1000), 1'b1, 1'b1);
        tick();
        lookup_expect("sat_taken", VLEN'(32'h1000), 1'b1);
        upd(VLEN'(32'h1000), 1'b0, 1'b1);
        upd(VLEN'(32'h1000), 1'b0, 1'b1);
        tick();
        lookup_expect("sat_back_01", VLEN'(32'h1000), 1'b0);

        // Flush kills the update waiting in stage 1.
        upd_valid_i     = 1'b1;
        upd_is_branch_i = 1'b1;
        upd_pc_i        = VLEN'(32'h1000);
        upd_taken_i     = 1'b1;
        tick();
        upd_valid_i     = 1'b0;
        upd_is_branch_i = 1'b0;
        flush_and_wait("flush1");
        lookup_expect("flush_dropped", VLEN'(32'h1000), 1'b0);

        // Lookup in the write cycle sees the old value.
        upd(VLEN'(32'h2000), 1'b1, 1'b1);
        lookup_expect("rbw_same_cycle", VLEN'(32'h2000), 1'b0);
        lookup_expect("rbw_next_cycle", VLEN'(32'h2000), 1'b1);

        // Aliasing and non-branch updates.
        flush_and_wait("flush2");
        upd(VLEN'(32'h1100), 1'b1, 1'b1);
        upd(VLEN'(32'h1100), 1'b1, 1'b1);
        tick();
        lookup_expect("alias_taken", VLEN'(32'h1000), 1'b1);
        upd(VLEN'(32'h1000), 1'b0, 1'b0);
        upd(VLEN'(32'h1000), 1'b0, 1'b0);
        tick();
        lookup_expect("non_branch_ignored", VLEN'(32'h1000), 1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst_i           = ($urandom_range(0, 599) == 0);
            flush_i         = ($urandom_range(0, 149) == 0);
            lookup_valid_i  = $urandom_range(0, 1) == 1;
            vpc_i           = (VLEN'($urandom_range(0, 255)) << 2) | (VLEN'($urandom_range(0, 7)) << 12);
            upd_valid_i     = $urandom_range(0, 2) != 0;
            upd_is_branch_i = $urandom_range(0, 3) != 0;
            upd_pc_i        = (VLEN'($urandom_range(0, 255)) << 2) | (VLEN'($urandom_range(0, 7)) << 12);
            upd_taken_i     = $urandom_range(0, 1) == 1;
            tick();
        end
        rst_i          = 1'b0;
        flush_i        = 1'b0;
        lookup_valid_i = 1'b0;
        upd_valid_i    = 1'b0;
        tick();
        tick();
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
